// File: rtl/seg7_pkg.sv
// seg7_pkg: shared cathode/anode encodings, digit type and scan-state enum for 7-segment checkers
package seg7_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        CAPTURED
    } state_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode selects, one bit low per digit
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    function automatic logic an_legal(input logic [3:0] an);
        return an == AN_D0 || an == AN_D1 || an == AN_D2 || an == AN_D3;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        return an == AN_D1 ? 2'd1 : an == AN_D2 ? 2'd2 : an == AN_D3 ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low cathode pattern back to its BCD digit, flagging unknown patterns
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output digit_t     digit_o
);

    // Table lookup; anything outside the ten digit glyphs is a miss
    always_comb begin
        hit_o   = 1'b1;
        digit_o = 4'd0;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: hit_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers four BCD digits from a multiplexed active-low 7-segment bus and publishes frames
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    input  logic        clear_i,
    output logic [15:0] digits_o,
    output logic [3:0]  valid_o,
    output logic        frame_o,
    output logic [15:0] frame_digits_o,
    output logic        err_o,
    output logic [1:0]  err_digit_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [15:0]      digits_q, digits_d, frame_digits_q;
    logic [3:0]       valid_q, valid_d, valid_set;
    logic             frame_q, err_q;
    logic [1:0]       err_digit_q;

    logic       changed, legal, settled, capture, good, bad, frame_done, hit;
    logic [1:0] idx;
    digit_t     dec;

    assign changed = {an_i, seg_i} != {an_q, seg_q};
    assign legal   = an_legal(an_i);
    assign idx     = an_index(an_i);
    assign settled = cnt_q == CNT_W'(SETTLE_CYCLES - 1);

    seg7_pattern_decode u_decode (
        .seg_i   (seg_i),
        .hit_o   (hit),
        .digit_o (dec)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT;
        else        state_q <= state_d;
    end

    // Next state: clear or a bad anode parks in WAIT; any input change restarts the dwell
    always_comb begin
        state_d = state_q;
        if (clear_i || !legal) state_d = WAIT;
        else begin
            case (state_q)
                WAIT:     state_d = SETTLE;
                SETTLE:   state_d = (!changed && settled) ? CAPTURED : SETTLE;
                CAPTURED: state_d = changed ? SETTLE : CAPTURED;
                default:  state_d = WAIT;
            endcase
        end
    end

    // FSM outputs: one capture per dwell, clear suppresses it entirely
    always_comb begin
        capture = !clear_i && legal && state_q == SETTLE && !changed && settled;
        good    = capture && hit;
        bad     = capture && !hit;
    end

    // Datapath next values: digit load, frame-tracking bits and stability counter
    always_comb begin
        digits_d = digits_q;
        if (good) digits_d[idx*4 +: 4] = dec;
        valid_set  = valid_q | (good ? 4'b0001 << idx : 4'b0000);
        frame_done = good && &valid_set;
        valid_d    = (clear_i || frame_done) ? 4'b0000 : valid_set;
        cnt_d      = (clear_i || changed) ? '0 :
                     (cnt_q == CNT_W'(SETTLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Input samplers, counter, digit/frame/error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q           <= AN_NONE;
            seg_q          <= SEG_BLANK;
            cnt_q          <= '0;
            digits_q       <= '0;
            valid_q        <= '0;
            frame_q        <= 1'b0;
            frame_digits_q <= '0;
            err_q          <= 1'b0;
            err_digit_q    <= '0;
        end else begin
            an_q    <= an_i;
            seg_q   <= seg_i;
            cnt_q   <= cnt_d;
            digits_q <= digits_d;
            valid_q <= valid_d;
            frame_q <= frame_done;
            err_q   <= bad;
            if (frame_done) frame_digits_q <= digits_d;
            if (bad)        err_digit_q    <= idx;
        end
    end

    assign digits_o       = digits_q;
    assign valid_o        = valid_q;
    assign frame_o        = frame_q;
    assign frame_digits_o = frame_digits_q;
    assign err_o          = err_q;
    assign err_digit_o    = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed-vector check of the scan decoder with hand-computed expectations
module tb_seg7_scan_decoder;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                           S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                           S8 = 7'b0000000, S9 = 7'b0010000, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_i = 4'hF;
    logic [6:0]  seg_i = 7'h7F;
    logic        clear_i = 1'b0;
    logic [15:0] digits_o, frame_digits_o;
    logic [3:0]  valid_o;
    logic        frame_o, err_o;
    logic [1:0]  err_digit_o;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    seg7_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .an_i           (an_i),
        .seg_i          (seg_i),
        .clear_i        (clear_i),
        .digits_o       (digits_o),
        .valid_o        (valid_o),
        .frame_o        (frame_o),
        .frame_digits_o (frame_digits_o),
        .err_o          (err_o),
        .err_digit_o    (err_digit_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive an/seg, then step n edges sampling 1 time unit after each edge
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an_i  = a;
        seg_i = s;
        repeat (n) begin
            @(posedge clk);
            #1;
            frame_cnt += int'(frame_o);
            err_cnt   += int'(err_o);
        end
    endtask

    initial begin
        // 1: reset state and idle blank bus
        repeat (2) @(posedge clk);
        #1;
        check("rst_digits", digits_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_fdigits", frame_digits_o, 0);
        check("rst_err", err_o, 0);
        check("rst_errdig", err_digit_o, 0);
        rst_n = 1'b1;
        hold(4'hF, SB, 10);
        check("idle_pulses", frame_cnt + err_cnt, 0);
        check("idle_valid", valid_o, 0);

        // 2: capture latency is exactly 5 edges, single capture over a long dwell
        hold(4'hE, S2, 4);
        check("lat_early_valid", valid_o, 4'b0000);
        check("lat_early_digits", digits_o, 16'h0000);
        hold(4'hE, S2, 1);
        check("lat_valid", valid_o, 4'b0001);
        check("lat_digits", digits_o, 16'h0002);
        hold(4'hE, S2, 15);
        check("long_valid", valid_o, 4'b0001);
        check("long_frames", frame_cnt, 0);

        // 3: full scan 1,2,3,4 produces one frame
        hold(4'hE, S1, 6);
        hold(4'hD, S2, 6);
        hold(4'hB, S3, 6);
        hold(4'h7, S4, 4);
        check("scan_pre_valid", valid_o, 4'b0111);
        check("scan_pre_frame", frame_o, 0);
        hold(4'h7, S4, 1);
        check("scan_frame", frame_o, 1);
        check("scan_fdigits", frame_digits_o, 16'h4321);
        check("scan_valid", valid_o, 4'b0000);
        check("scan_digits", digits_o, 16'h4321);
        hold(4'h7, S4, 3);
        check("scan_frame_once", frame_cnt, 1);
        check("scan_pulse_low", frame_o, 0);

        // 4: glitch on digit1 never captures the transient value
        hold(4'hD, S1, 2);
        check("glitch_mid", digits_o, 16'h4321);
        hold(4'hD, S3, 5);
        check("glitch_digits", digits_o, 16'h4331);
        check("glitch_valid", valid_o, 4'b0010);

        // 5: unknown pattern on digit2, then illegal anodes
        hold(4'hB, SB, 5);
        check("err_pulse", err_o, 1);
        check("err_digit", err_digit_o, 2);
        check("err_digits", digits_o, 16'h4331);
        check("err_valid", valid_o, 4'b0010);
        hold(4'hB, SB, 15);
        check("err_once", err_cnt, 1);
        hold(4'hC, S5, 10);
        hold(4'hF, S5, 10);
        check("illegal_err", err_cnt, 1);
        check("illegal_digits", digits_o, 16'h4331);
        check("illegal_valid", valid_o, 4'b0010);

        // 6: clear on the digit3 capture edge suppresses the frame
        hold(4'hE, S5, 6);
        hold(4'hD, S6, 6);
        hold(4'hB, S7, 6);
        check("clr_pre_valid", valid_o, 4'b0111);
        hold(4'h7, S8, 4);
        clear_i = 1'b1;
        hold(4'h7, S8, 1);
        clear_i = 1'b0;
        check("clr_frame", frame_o, 0);
        check("clr_valid", valid_o, 4'b0000);
        check("clr_digits", digits_o, 16'h4765);
        check("clr_errdig", err_digit_o, 2);
        hold(4'hF, SB, 3);
        check("clr_frames", frame_cnt, 1);
        hold(4'hE, S9, 6);
        hold(4'hD, S0, 6);
        hold(4'hB, S1, 6);
        hold(4'h7, S2, 6);
        check("rescan_frames", frame_cnt, 2);
        check("rescan_fdigits", frame_digits_o, 16'h2109);
        check("rescan_valid", valid_o, 4'b0000);

        // 7: asynchronous reset mid-dwell clears everything at once
        hold(4'hE, S3, 6);
        hold(4'hD, S3, 3);
        check("pre_rst_valid", valid_o, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digits", digits_o, 0);
        check("arst_valid", valid_o, 0);
        check("arst_fdigits", frame_digits_o, 0);
        check("arst_errdig", err_digit_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'hF, SB, 3);
        check("post_rst_valid", valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Recovers the four BCD digits from a multiplexed, active-low 7-segment display bus, performing the inverse of the digit-select and cathode-encode path. It samples the anode and cathode lines and waits for each digit dwell to settle. It then decodes the cathode pattern back to BCD and stores it per digit. When all four digits have been captured, it publishes a frame snapshot. It is used as a display-loopback checker and as a scoreboard source for counter-display tests.

Parameters:
SETTLE_CYCLES, 4, number of consecutive cycles an_i/seg_i must be unchanged before a capture (legal range 1 to 255)
CNT_W, $clog2(SETTLE_CYCLES+1), width of the stability counter (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
an_i  in  4  anodes, active-low: 1110 selects digit0, 1101 digit1, 1011 digit2, 0111 digit3
seg_i  in  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
clear_i  in  1  synchronous clear of the frame in progress
digits_o  out  16  live digit registers {d3,d2,d1,d0}, 4 bits each
valid_o  out  4  per-digit captured-this-frame flags
frame_o  out  1  one-cycle pulse when a frame is complete
frame_digits_o  out  16  snapshot {d3,d2,d1,d0}, loaded together with frame_o
err_o  out  1  one-cycle pulse when an unrecognised cathode pattern is captured
err_digit_o  out  2  index of the digit that raised err_o; holds its value until the next error

Behaviour:
- Reset (async assert, sync release): all outputs 0; an_q=4'hF; seg_q=7'h7F; cnt=0; state WAIT.
- Sample registers: an_q and seg_q load an_i and seg_i every cycle.
- Stability counter:
  - If {an_i,seg_i} != {an_q,seg_q}, cnt<=0.
  - Otherwise cnt increments and saturates at SETTLE_CYCLES.
- Anode check: a legal anode is exactly one bit low. Blank (1111) and multi-low values are illegal. An illegal anode forces state WAIT, and no capture or error occurs.
- States:
  - WAIT → SETTLE when the anode is legal.
  - SETTLE → CAPTURED on the cycle where cnt==SETTLE_CYCLES-1 and the inputs are unchanged. Capture happens on this edge.
  - Any input change in SETTLE or CAPTURED → SETTLE if the new anode is legal, else WAIT.
  - CAPTURED holds with no further captures, so there is exactly one capture per dwell.
- Latency: inputs held constant across SETTLE_CYCLES+1 rising edges produce a capture. Its results are visible after the (SETTLE_CYCLES+1)th edge.
- Decode table (seg_i → BCD):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
- Good capture: the selected digit register is loaded and its valid_o bit is set.
- Bad capture (any other pattern):
  - err_o pulses for one cycle and err_digit_o is loaded with the index.
  - The digit register and valid bit are unchanged.
- Frame complete: if a good capture makes valid_o all-ones (counting that cycle's capture), then on the next edge:
  - frame_o pulses for one cycle.
  - frame_digits_o loads the updated digits.
  - valid_o clears to 0.
- Repeated capture of an already-valid digit overwrites its register and does not affect frame tracking.
- clear_i has priority over a same-cycle capture:
  - valid_o is cleared, state goes to WAIT, cnt is cleared.
  - digits_o, frame_digits_o and err_digit_o are retained.
  - No frame_o or err_o is produced.
- Reset mid-dwell: everything returns to reset values immediately, and the partial frame is discarded.

Decomposition:
- Package seg7_pkg:
  - digit_t (logic [3:0])
  - SEG_0..SEG_9 and SEG_BLANK cathode constants
  - AN_D0..AN_D3 anode constants
  - state enum (WAIT, SETTLE, CAPTURED)
- Sub-module seg7_pattern_decode: combinational, seg[6:0] → {hit, digit_t}, built from the package constants. It is shared with future display checkers.

Test Plan:
1. Reset: assert rst_n=0 mid-clock → all outputs 0 immediately; after release, no pulses with an_i=1111.
2. an_i=1110, seg_i=0100100 held 5 edges (SETTLE_CYCLES=4) → digits_o=16'h0002, valid_o=0001 after edge 5; none before; exactly one capture over 20 held cycles.
3. Scan digits 0..3 with patterns for 1,2,3,4, each held 6 cycles → after the digit3 capture, frame_o pulses once, frame_digits_o=16'h4321, valid_o=0000.
4. Glitch: an_i=1101 with seg 1111001 for 2 cycles, then seg 0110000 for 5 → digit1=3 only; value 1 is never captured.
5. an_i=1011, seg_i=1111111 held 5 cycles → err_o single pulse, err_digit_o=2, digit2 and valid_o[2] unchanged. Then an_i=1100 and 1111 held 10 cycles each → no capture, no error.
6. Digits 0–2 valid, clear_i asserted on the digit3 capture edge → no frame_o, valid_o=0000, digits_o retained; the next full scan produces a normal frame.
